// File: rtl/note_seq_pkg.sv
// note_seq_pkg
//   Shared definitions for the note sequencer: command byte codes received
//   over the UART byte stream, and the state encodings of the command parser
//   and of the score player.
package note_seq_pkg;

    // Command bytes (only meaningful while the parser is in P_CMD)
    localparam logic [7:0] CMD_PLAY_ONCE = 8'h01;
    localparam logic [7:0] CMD_PLAY_LOOP = 8'h02;
    localparam logic [7:0] CMD_STOP      = 8'h03;
    localparam logic [7:0] CMD_CLEAR     = 8'h04;
    localparam logic [7:0] CMD_LOAD      = 8'h10;

    // Command parser: P_CMD waits for a command, the other three collect the
    // payload of a LOAD frame (note, dur high byte, dur low byte).
    typedef enum logic [1:0] {
        P_CMD  = 2'd0,
        P_NOTE = 2'd1,
        P_DHI  = 2'd2,
        P_DLO  = 2'd3
    } parse_state_t;

    // Score player
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        NOTE  = 2'd2,
        GAP   = 2'd3
    } play_state_t;

endpackage

// File: rtl/note_sequencer_tick_gen.sv
// tick_gen
//   Free-running prescaler producing a one-cycle clock-enable pulse every
//   CLK_FREQ/TICK_HZ cycles of sys_clk. It is never restarted by commands,
//   so the phase of the tick relative to a note start is arbitrary.
//
// Ports
//   sys_clk  in   system clock
//   sys_rst  in   asynchronous reset, active high (prescaler to 0)
//   tick     out  one-cycle enable pulse, last cycle of each prescaler period
module tick_gen #(
    parameter int CLK_FREQ = 12000000,
    parameter int TICK_HZ  = 1000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic tick
);

    // A divide ratio below 1 would be meaningless; clamp so tick is simply
    // asserted every cycle in that case.
    localparam int DIV = (CLK_FREQ / TICK_HZ < 1) ? 1 : CLK_FREQ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
//   Score player for the beeper path. A byte command stream (from the UART
//   receiver) loads {note, duration} entries into an internal score RAM and
//   starts/stops playback, once or looped. Durations are counted in ticks of
//   a free-running clock-enable; everything runs on sys_clk.
//
// Parameters
//   CLK_FREQ   sys_clk frequency in Hz
//   TICK_HZ    duration unit rate (1000 -> 1 ms ticks)
//   DEPTH      score RAM entries, power of two, >= 2
//   NOTE_W     tone code width, <= 8
//   DUR_W      duration width in ticks, <= 16
//   GAP_TICKS  silent ticks after each played note, 0 disables the gap
//
// Ports
//   sys_clk    in   the only clock
//   sys_rst    in   asynchronous reset, active high
//   cmd_valid  in   one-cycle strobe, one byte per strobe
//   cmd_data   in   command or payload byte
//   tone_en    out  Beeper tone enable
//   tone       out  Beeper tone code (held while silent)
//   busy       out  high while playing
//   done       out  one-cycle pulse at the end of a one-shot playback
//   err        out  one-cycle pulse when a LOAD frame is dropped
//   score_len  out  number of loaded entries
module note_sequencer #(
    parameter int CLK_FREQ  = 12000000,
    parameter int TICK_HZ   = 1000,
    parameter int DEPTH     = 128,
    parameter int NOTE_W    = 5,
    parameter int DUR_W     = 16,
    parameter int GAP_TICKS = 10
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     cmd_valid,
    input  logic [7:0]               cmd_data,
    output logic                     tone_en,
    output logic [NOTE_W-1:0]        tone,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   score_len
);

    import note_seq_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = NOTE_W + DUR_W;
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);
    localparam logic [15:0]   GAP_LAST = 16'(GAP_TICKS);

    // ------------------------------------------------------------------
    // Tick prescaler
    // ------------------------------------------------------------------
    logic tick;

    tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tick    (tick)
    );

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    parse_state_t       p_st;
    logic [NOTE_W-1:0]  note_buf;
    logic [7:0]         dhi_buf;
    logic [15:0]        dur_full;
    logic [DUR_W-1:0]   dur_in;

    logic cmd_now;
    logic play_once_cmd;
    logic play_loop_cmd;
    logic play_cmd;
    logic stop_cmd;
    logic load_last;
    logic load_ok;

    // Command codes only count in P_CMD; inside a LOAD frame they are payload.
    assign cmd_now       = cmd_valid && (p_st == P_CMD);
    assign play_once_cmd = cmd_now && (cmd_data == CMD_PLAY_ONCE);
    assign play_loop_cmd = cmd_now && (cmd_data == CMD_PLAY_LOOP);
    assign play_cmd      = play_once_cmd || play_loop_cmd;
    assign stop_cmd      = cmd_now && (cmd_data == CMD_STOP);

    assign dur_full  = {dhi_buf, cmd_data};
    assign dur_in    = dur_full[DUR_W-1:0];
    assign load_last = cmd_valid && (p_st == P_DLO);
    // The score is frozen while playing so the player's view of score_len
    // and RAM contents cannot change under it.
    assign load_ok   = load_last && !busy && (score_len != FULL);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            p_st      <= P_CMD;
            note_buf  <= '0;
            dhi_buf   <= '0;
            score_len <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (cmd_valid) begin
                case (p_st)
                    P_CMD: begin
                        if (cmd_data == CMD_LOAD) begin
                            p_st <= P_NOTE;
                        end else if (cmd_data == CMD_CLEAR && !busy) begin
                            score_len <= '0;
                        end
                    end
                    P_NOTE: begin
                        note_buf <= cmd_data[NOTE_W-1:0];
                        p_st     <= P_DHI;
                    end
                    P_DHI: begin
                        dhi_buf <= cmd_data;
                        p_st    <= P_DLO;
                    end
                    P_DLO: begin
                        p_st <= P_CMD;
                        if (load_ok) begin
                            score_len <= score_len + LW'(1);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: p_st <= P_CMD;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Score RAM (not reset, synchronous read)
    // ------------------------------------------------------------------
    logic [EW-1:0]     ram [DEPTH];
    logic [EW-1:0]     rd_data;
    logic [AW-1:0]     rd_addr;
    logic [NOTE_W-1:0] rd_note;
    logic [DUR_W-1:0]  rd_dur;

    always_ff @(posedge sys_clk) begin
        if (load_ok) begin
            ram[score_len[AW-1:0]] <= {note_buf, dur_in};
        end
        rd_data <= ram[rd_addr];
    end

    assign rd_note = rd_data[EW-1:DUR_W];
    assign rd_dur  = rd_data[DUR_W-1:0];

    // ------------------------------------------------------------------
    // Player
    // ------------------------------------------------------------------
    play_state_t      pl_st;
    logic [AW-1:0]    idx;
    logic             loop_mode;
    logic [15:0]      tcnt;
    logic [DUR_W-1:0] cur_dur;

    logic last;
    logic note_end;
    logic adv;

    assign last     = ({1'b0, idx} == (score_len - LW'(1)));
    assign note_end = (pl_st == NOTE) && (tcnt == 16'(cur_dur));

    // Leave the current entry: silent entry skipped straight from FETCH,
    // note end with no gap configured, or gap finished.
    assign adv = ((pl_st == FETCH) && (rd_dur == '0))
              || (note_end && (GAP_TICKS == 0))
              || ((pl_st == GAP) && (tcnt == GAP_LAST));

    // The read address is the index the player is about to enter FETCH
    // with, so the RAM word is already registered during the FETCH cycle.
    assign rd_addr = (play_cmd || last) ? '0 : idx + AW'(1);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pl_st     <= IDLE;
            idx       <= '0;
            loop_mode <= 1'b0;
            tcnt      <= '0;
            cur_dur   <= '0;
            tone      <= '0;
            tone_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop_cmd) begin
                pl_st   <= IDLE;
                tone_en <= 1'b0;
                busy    <= 1'b0;
            end else if (play_cmd) begin
                tone_en <= 1'b0;
                if (score_len == '0) begin
                    // Nothing to play: report completion immediately.
                    pl_st <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    pl_st     <= FETCH;
                    idx       <= '0;
                    loop_mode <= play_loop_cmd;
                    busy      <= 1'b1;
                end
            end else if (adv) begin
                tone_en <= 1'b0;
                if (!last) begin
                    idx   <= idx + AW'(1);
                    pl_st <= FETCH;
                end else if (loop_mode) begin
                    idx   <= '0;
                    pl_st <= FETCH;
                end else begin
                    pl_st <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else begin
                case (pl_st)
                    FETCH: begin
                        // dur==0 never gets here (handled by adv)
                        tone    <= rd_note;
                        cur_dur <= rd_dur;
                        tcnt    <= '0;
                        tone_en <= 1'b1;
                        pl_st   <= NOTE;
                    end
                    NOTE: begin
                        if (note_end) begin
                            tone_en <= 1'b0;
                            tcnt    <= '0;
                            pl_st   <= GAP;
                        end else if (tick) begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
    import note_seq_pkg::*;

    localparam int DEPTH  = 4;
    localparam int NOTE_W = 5;
    localparam int DUR_W  = 16;
    localparam int GAPT   = 10;
    localparam int TPER   = 12;   // cycles per tick at 12000/1000
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              sys_clk   = 1'b0;
    logic              sys_rst   = 1'b1;
    logic              cmd_valid = 1'b0;
    logic [7:0]        cmd_data  = 8'h00;
    logic              tone_en;
    logic [NOTE_W-1:0] tone;
    logic              busy;
    logic              done;
    logic              err;
    logic [LW-1:0]     score_len;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int note;
        int dur;
    } exp_t;
    exp_t exp_q[$];

    int cyc       = 0;
    int rise_cyc  = 0;
    int fall_cyc  = 0;
    int cur_dur   = 0;
    int done_seen = 0;
    bit prev_en   = 1'b0;
    bit gap_armed = 1'b0;
    bit cut       = 1'b0;

    note_sequencer #(
        .CLK_FREQ  (12000),
        .TICK_HZ   (1000),
        .DEPTH     (DEPTH),
        .NOTE_W    (NOTE_W),
        .DUR_W     (DUR_W),
        .GAP_TICKS (GAPT)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .tone_en   (tone_en),
        .tone      (tone),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .score_len (score_len)
    );

    always #5 sys_clk = ~sys_clk;

    // Scoreboard monitor: every audible note pops one expected entry; its
    // tone, its audible length and the silence before it are checked.
    always @(negedge sys_clk) begin
        cyc++;
        if (done === 1'b1) done_seen++;
        if (tone_en === 1'b1 && !prev_en) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL note_unexpected: tone=%0d with no note expected", tone);
                cur_dur = 0;
            end else begin
                e = exp_q.pop_front();
                cur_dur = e.dur;
                if (tone !== NOTE_W'(e.note)) begin
                    failures++;
                    $display("FAIL note_tone: got %0d want %0d", tone, e.note);
                end
                if (gap_armed) begin
                    checks++;
                    if ((cyc - fall_cyc) < TPER*(GAPT-1)+1 || (cyc - fall_cyc) > TPER*GAPT+3) begin
                        failures++;
                        $display("FAIL gap_len: got %0d cycles want %0d..%0d",
                                 cyc - fall_cyc, TPER*(GAPT-1)+1, TPER*GAPT+3);
                    end
                end
            end
            rise_cyc = cyc;
        end
        if (tone_en !== 1'b1 && prev_en) begin
            if (!cut) begin
                checks++;
                if ((cyc - rise_cyc) < TPER*(cur_dur-1) || (cyc - rise_cyc) > TPER*cur_dur+2) begin
                    failures++;
                    $display("FAIL note_len: got %0d cycles want %0d..%0d",
                             cyc - rise_cyc, TPER*(cur_dur-1), TPER*cur_dur+2);
                end
            end
            fall_cyc  = cyc;
            gap_armed = 1'b1;
        end
        prev_en = (tone_en === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        cmd_valid = 1'b1;
        cmd_data  = b;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic load_entry(input int note, input int dur);
        logic [15:0] d;
        d = 16'(dur);
        send_byte(CMD_LOAD);
        send_byte(8'(note));
        send_byte(d[15:8]);
        send_byte(d[7:0]);
    endtask

    task automatic push_exp(input int note, input int dur);
        exp_t e;
        e.note = note;
        e.dur  = dur;
        exp_q.push_back(e);
    endtask

    task automatic play(input logic [7:0] c);
        send_byte(c);
        gap_armed = 1'b0;
        cut       = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output logic b);
        seen = 1'b0;
        b    = 1'bx;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                b    = busy;
                break;
            end
        end
    endtask

    task automatic wait_en(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (tone_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({tone_en, tone, busy, done, err, score_len} !== '0) begin
            failures++;
            $display("FAIL reset_values: en=%b tone=%0d busy=%b done=%b err=%b len=%0d want all 0",
                     tone_en, tone, busy, done, err, score_len);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0 || tone_en !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: busy=%b en=%b want 0 0", busy, tone_en);
        end
    endtask

    task automatic test_play_once();
        bit seen;
        logic b;
        load_entry(6, 20);
        load_entry(7, 20);
        load_entry(8, 20);
        @(negedge sys_clk);
        checks++;
        if (score_len !== LW'(3)) begin
            failures++;
            $display("FAIL once_len: got %0d want 3", score_len);
        end
        push_exp(6, 20); push_exp(7, 20); push_exp(8, 20);
        play(CMD_PLAY_ONCE);
        @(negedge sys_clk);   // t+1
        checks++;
        if (busy !== 1'b1 || tone_en !== 1'b0) begin
            failures++;
            $display("FAIL once_t1: busy=%b en=%b want 1 0", busy, tone_en);
        end
        @(negedge sys_clk);   // t+2
        checks++;
        if (tone_en !== 1'b1 || tone !== NOTE_W'(6)) begin
            failures++;
            $display("FAIL once_t2: en=%b tone=%0d want 1 6", tone_en, tone);
        end
        wait_done(3000, seen, b);
        checks++;
        if (!seen || b !== 1'b0) begin
            failures++;
            $display("FAIL once_done: seen=%b busy=%b want 1 0", seen, b);
        end
        @(negedge sys_clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0 || score_len !== LW'(3)) begin
            failures++;
            $display("FAIL once_after: done=%b busy=%b left=%0d len=%0d want 0 0 0 3",
                     done, busy, exp_q.size(), score_len);
        end
    endtask

    task automatic test_loop_stop();
        int d0;
        bit ok;
        send_byte(CMD_CLEAR);
        load_entry(9, 3);
        load_entry(10, 3);
        for (int i = 0; i < 3; i++) begin
            push_exp(9, 3);
            push_exp(10, 3);
        end
        d0 = done_seen;
        play(CMD_PLAY_LOOP);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge sys_clk);
            if (exp_q.size() == 0 && tone_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || tone !== NOTE_W'(10)) begin
            failures++;
            $display("FAIL loop_wrap: reached=%b tone=%0d want 1 10", ok, tone);
        end
        repeat (3) @(negedge sys_clk);
        cut = 1'b1;
        send_byte(CMD_STOP);
        @(negedge sys_clk);
        checks++;
        if (tone_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL stop_t1: en=%b busy=%b done=%b want 0 0 0", tone_en, busy, done);
        end
        repeat (300) @(negedge sys_clk);
        checks++;
        if (done_seen != d0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL loop_no_done: done pulses=%0d busy=%b want 0 0", done_seen - d0, busy);
        end
    endtask

    task automatic test_overflow();
        bit seen;
        logic b;
        send_byte(CMD_CLEAR);
        for (int i = 1; i <= 4; i++) load_entry(i, 2);
        @(negedge sys_clk);
        checks++;
        if (score_len !== LW'(4) || err !== 1'b0) begin
            failures++;
            $display("FAIL full_len: len=%0d err=%b want 4 0", score_len, err);
        end
        load_entry(5, 2);
        @(negedge sys_clk);
        checks++;
        if (err !== 1'b1 || score_len !== LW'(4)) begin
            failures++;
            $display("FAIL full_err: err=%b len=%0d want 1 4", err, score_len);
        end
        @(negedge sys_clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL full_err_width: err=%b want 0", err);
        end
        for (int i = 1; i <= 4; i++) push_exp(i, 2);
        play(CMD_PLAY_ONCE);
        load_entry(31, 2);
        @(negedge sys_clk);
        checks++;
        if (err !== 1'b1 || score_len !== LW'(4) || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_load_err: err=%b len=%0d busy=%b want 1 4 1", err, score_len, busy);
        end
        wait_done(3000, seen, b);
        checks++;
        if (!seen || b !== 1'b0) begin
            failures++;
            $display("FAIL full_done1: seen=%b busy=%b want 1 0", seen, b);
        end
        // Replay: the monitor proves the RAM kept notes 1..4.
        for (int i = 1; i <= 4; i++) push_exp(i, 2);
        play(CMD_PLAY_ONCE);
        wait_done(3000, seen, b);
        checks++;
        if (!seen || exp_q.size() != 0) begin
            failures++;
            $display("FAIL full_replay: seen=%b left=%0d want 1 0", seen, exp_q.size());
        end
    endtask

    task automatic test_dur0();
        bit seen;
        logic b;
        send_byte(CMD_CLEAR);
        load_entry(5, 3);
        load_entry(6, 0);
        load_entry(7, 3);
        push_exp(5, 3);
        push_exp(7, 3);
        play(CMD_PLAY_ONCE);
        wait_done(2000, seen, b);
        checks++;
        if (!seen || b !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL dur0_done: seen=%b busy=%b left=%0d want 1 0 0", seen, b, exp_q.size());
        end
    endtask

    task automatic test_empty_clear();
        send_byte(CMD_CLEAR);
        @(negedge sys_clk);
        checks++;
        if (score_len !== '0) begin
            failures++;
            $display("FAIL clear_len: got %0d want 0", score_len);
        end
        play(CMD_PLAY_ONCE);
        @(negedge sys_clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_play: done=%b busy=%b want 1 0", done, busy);
        end
        @(negedge sys_clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_done_width: done=%b busy=%b want 0 0", done, busy);
        end
        load_entry(3, 5);
        push_exp(3, 5);
        play(CMD_PLAY_LOOP);
        send_byte(CMD_CLEAR);
        @(negedge sys_clk);
        checks++;
        if (score_len !== LW'(1) || busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_busy: len=%0d busy=%b want 1 1", score_len, busy);
        end
        cut = 1'b1;
        send_byte(CMD_STOP);
        @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0 || tone_en !== 1'b0) begin
            failures++;
            $display("FAIL clear_stop: busy=%b en=%b want 0 0", busy, tone_en);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic b;
        send_byte(CMD_CLEAR);
        load_entry(12, 20);
        load_entry(13, 20);
        push_exp(12, 20);
        push_exp(13, 20);
        play(CMD_PLAY_ONCE);
        wait_en(100, seen);
        repeat (5) @(negedge sys_clk);
        cut = 1'b1;
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if (seen !== 1'b1 || {tone_en, tone, busy, done, err, score_len} !== '0) begin
            failures++;
            $display("FAIL rst_mid_note: played=%b en=%b tone=%0d busy=%b done=%b err=%b len=%0d want 1 then all 0",
                     seen, tone_en, tone, busy, done, err, score_len);
        end
        exp_q.delete();
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        load_entry(3, 2);
        @(negedge sys_clk);
        checks++;
        if (score_len !== LW'(1)) begin
            failures++;
            $display("FAIL rst_reload: len=%0d want 1", score_len);
        end
        send_byte(CMD_LOAD);
        send_byte(8'd9);
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if ({tone_en, tone, busy, done, err, score_len} !== '0) begin
            failures++;
            $display("FAIL rst_mid_load: en=%b tone=%0d busy=%b len=%0d want all 0",
                     tone_en, tone, busy, score_len);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        load_entry(4, 2);
        @(negedge sys_clk);
        checks++;
        if (score_len !== LW'(1) || err !== 1'b0) begin
            failures++;
            $display("FAIL rst_fresh_load: len=%0d err=%b want 1 0", score_len, err);
        end
        push_exp(4, 2);
        play(CMD_PLAY_ONCE);
        wait_done(1000, seen, b);
        checks++;
        if (!seen || b !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_fresh_play: seen=%b busy=%b left=%0d want 1 0 0", seen, b, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_play_once();
        test_loop_stop();
        test_overflow();
        test_dur0();
        test_empty_clear();
        test_reset_mid();
        repeat (5) @(negedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Parametrised score player for the beeper path. A byte-command interface, fed by the UART receive chain, loads a note/duration score into internal RAM and starts or stops playback once or in a loop. The block drives the tone code and tone enable of the existing `Beeper`. It runs entirely on `sys_clk`: a 1 ms tick is a clock-enable pulse, and no derived clock is used.

## Interface
- `CLK_FREQ`, 12000000: `sys_clk` frequency in Hz.
- `TICK_HZ`, 1000: duration unit rate; one tick equals 1 ms at the default.
- `DEPTH`, 128: score RAM entries, power of two, at least 2.
- `NOTE_W`, 5: tone code width; must be 8 or less.
- `DUR_W`, 16: duration width in ticks; must be 16 or less.
- `GAP_TICKS`, 10: silent ticks inserted after every played note; 0 disables the gap.

Ports:
- `sys_clk` in, 1: the only clock.
- `sys_rst` in, 1: asynchronous reset, active-high.
- `cmd_valid` in, 1: single-cycle strobe, one byte per strobe (the rising-edge pulse of UART recv done).
- `cmd_data` in, 8: command or payload byte.
- `tone_en` out, 1: drives Beeper `tone_en`.
- `tone` out, NOTE_W: drives Beeper `tone`.
- `busy` out, 1: high while playing.
- `done` out, 1: one-cycle pulse at the end of a one-shot playback.
- `err` out, 1: one-cycle pulse when a LOAD frame is dropped.
- `score_len` out, $clog2(DEPTH)+1: number of loaded entries.

## Operation
Command parser states are P_CMD, P_NOTE, P_DHI, P_DLO. Every byte is consumed on `cmd_valid`.
- `0x01` PLAY_ONCE, `0x02` PLAY_LOOP: start at index 0.
  - Ignored if `score_len`==0, except that `done` pulses.
  - Issued while playing, restarts at index 0 with the new mode.
- `0x03` STOP: go to IDLE. `tone_en` drops and `done` does not pulse.
- `0x04` CLEAR: `score_len` goes to 0. Ignored while `busy`.
- `0x10` LOAD: the next three bytes are note, dur[15:8], dur[7:0].
  - The parser goes P_NOTE, then P_DHI, then P_DLO, then back to P_CMD.
  - On the last byte, the entry `{note[NOTE_W-1:0], dur[DUR_W-1:0]}` is written at `score_len`, and `score_len` increments.
  - Upper bits beyond the widths are truncated.
  - If `busy` or `score_len`==DEPTH at the last byte: the frame is dropped, `err` pulses, and `score_len` is unchanged.
- All other bytes in P_CMD are ignored. There is no timeout; STOP/PLAY codes inside a LOAD frame are treated as payload.

Player states are IDLE, FETCH, NOTE, GAP.
- IDLE: `tone_en`=0, `busy`=0.
- FETCH (1 cycle): registered RAM read of `idx`.
- NOTE: `tone`=entry note, `tone_en`=1. The tick counter is cleared on entry and increments on each tick. Exit when count==dur.
  - dur==0: skip straight from FETCH to the next index with no GAP, and `tone_en` is never raised.
- GAP: `tone_en`=0 for GAP_TICKS ticks. This state is skipped if GAP_TICKS==0.
- Advance: if `idx`==`score_len`-1, then in loop mode `idx` goes to 0 and the player goes to FETCH. In once mode the player goes to IDLE and `done` pulses. Otherwise `idx`+1 and FETCH.
- `tone` holds its last value in IDLE and GAP; only `tone_en` gates sound.

## Timing
- Reset values: `tone_en`=0, `tone`=0, `busy`=0, `done`=0, `err`=0, `score_len`=0. Parser and player states are P_CMD and IDLE; the tick prescaler is 0. RAM contents are not reset.
- Reset asserted mid-playback or mid-frame: all of the above within the same cycle (asynchronous).
- Tick: one `sys_clk` pulse every CLK_FREQ/TICK_HZ cycles. It is free-running from reset and is not restarted by commands.
- PLAY byte at cycle t: `busy`=1 at t+1, FETCH at t+1, `tone`/`tone_en` valid at t+2.
- Note length is dur ticks after NOTE entry, so the audible time is between dur-1 and dur tick periods.
- STOP at cycle t: `tone_en`=0 and `busy`=0 at t+1.
- LOAD final byte at t: `score_len` updates at t+1. A PLAY at t+1 sees the new length.
- `done` and `err` are exactly one cycle wide. `done` coincides with `busy` falling.

## Structure
- Package `note_seq_pkg` holds the command codes (CMD_PLAY_ONCE, CMD_PLAY_LOOP, CMD_STOP, CMD_CLEAR, CMD_LOAD) and the parser/player state encodings.
- Sub-module `tick_gen` (params CLK_FREQ, TICK_HZ; ports `sys_clk`, `sys_rst`, `tick`) is the only natural split.
- Score RAM is inferred inside `note_sequencer`, with synchronous read.

## Test plan
Simulation uses CLK_FREQ=12000 and TICK_HZ=1000, so a tick occurs every 12 cycles.
- Load 3 entries (6/20, 7/20, 8/20) and send PLAY_ONCE: `tone` is 6, 7, 8 in sequence, each with `tone_en` high for about 20 ticks and 10 gap ticks between. `done` is a single pulse, `busy` falls, and `score_len`=3.
- PLAY_LOOP on 2 entries: after index 1 the player returns to note of index 0 without a `done` pulse. STOP mid-note gives `tone_en`=0 next cycle and no `done`.
- DEPTH=4: the 5th LOAD gives an `err` pulse and `score_len` stays 4. A LOAD during playback gives an `err` pulse and the RAM is unchanged.
- Entry with dur=0 between two notes: it is never audible, and the next note follows the previous GAP directly.
- PLAY with `score_len`=0: `done` pulses the next cycle and `busy` stays 0. CLEAR while busy is ignored.
- Assert `sys_rst` mid-NOTE and mid-LOAD frame: all outputs go to reset values immediately. A subsequent fresh LOAD parses correctly from P_CMD.
